nib_word_packer: RTL and testbench
==================================

Name: nib_word_packer

Overview:
Downstream of the colour detector. Takes one 2-bit colour code per detection-complete pulse and packs six codes, MSB-first, into one 12-bit program word. Writes each finished word into the program RAM's write port at an auto-incrementing address. Implements the cartridge-to-RAM load path that turns per-nib colour results into executable instructions.

Parameters:
NIBS_PER_WORD, 6, number of 2-bit nibs per RAM word
WORD_W, 12, RAM word width; must equal 2*NIBS_PER_WORD
ADDR_W, 8, RAM address width
MAX_WORDS, 256, highest writable word count; last address is MAX_WORDS-1

Ports:
clk  in  1  system clock (1 MHz domain)
reset  in  1  asynchronous, active-low
start  in  1  1-cycle pulse: clear address, nib count, flags; arm packer
nib_valid  in  1  1-cycle pulse: nib is a new colour code (colour detector completion strobe)
nib  in  2  colour code: 00 red, 01 green, 10 blue, 11 yellow
flush  in  1  1-cycle pulse: end of cartridge; zero-pad and write any partial word
wr_en  out  1  1-cycle RAM write strobe
wr_addr  out  ADDR_W  RAM write address, valid while wr_en=1
wr_data  out  WORD_W  RAM write data, valid while wr_en=1
word_count  out  ADDR_W+1  number of words written since start
busy  out  1  1 while in COLLECT
done  out  1  sticky; set by flush completion or full, cleared by start
overflow  out  1  sticky; a nib arrived while FULL; cleared by start

Behaviour:
- Reset (async, reset=0): state IDLE; shift register, nib counter, wr_addr, word_count = 0; wr_en, busy, done, overflow = 0; wr_data = 0.
- State IDLE: nib_valid and flush are ignored. A start pulse sends the block to COLLECT with all counters and flags cleared.
- State COLLECT, nib_valid=1:
  - Shift register becomes {sr[WORD_W-3:0], nib}. The first nib of a word therefore lands in bits [11:10].
  - Nib counter increments.
  - When the sampled nib is the NIBS_PER_WORD-th nib: on the same edge, wr_data <= {sr[WORD_W-3:0], nib}, wr_en <= 1, wr_addr <= current address, nib counter <= 0, sr <= 0.
  - Latency: wr_en is high in the cycle immediately after the edge that sampled the 6th nib_valid.
  - Back-to-back nib_valid every cycle must be supported with no nib loss.
- Address advance: the address register increments and word_count increments on the edge where wr_en is driven high. wr_addr holds the address being written.
- wr_en is a strict single-cycle pulse; wr_data and wr_addr hold their last values afterwards.
- Full: when a write targets address MAX_WORDS-1, state moves to FULL and done is set.
  - In FULL, any nib_valid sets overflow and the nib is dropped.
  - flush in FULL is ignored.
  - No address wrap-around, ever.
- Flush in COLLECT:
  - Nib counter = 0: no write; go to IDLE; set done.
  - Nib counter = k > 0: write {sr[2k-1:0], zeros(WORD_W-2k)} (pending nibs left-justified, zero-padded) with the same one-cycle latency as a normal write; go to IDLE; set done.
- nib_valid and flush on the same cycle:
  - The nib is accepted first, then flush applies to the result.
  - If that nib completes a word, exactly one write occurs (no extra padded word).
- start during any state, including mid-word or the same cycle as nib_valid: start wins. The partial word is discarded, no write is issued, the pending wr_en pulse is suppressed, and the block enters COLLECT cleared.
- Asynchronous reset mid-operation: immediate return to reset values. No write is completed.
- busy = (state == COLLECT). Output encoding: done and overflow are registered.

Optional Feature:
PACKER_CHECKSUM_EN
- Defined:
  - Adds output checksum[WORD_W-1:0], the running XOR of every wr_data actually written since start.
  - Updated on the same edge as wr_en. Cleared by reset and start.
  - Lets the CPU or debug LEDs confirm a clean cartridge read.
- Undefined: the checksum port is still present but tied to 0; no XOR logic is synthesised.

Test Plan:
1. reset, start, 6 nibs 11,10,01,00,11,10 spaced 40 cycles -> one wr_en pulse 1 cycle after the 6th nib, wr_addr=0, wr_data=12'hE4E, word_count=1.
2. start, 12 nibs on consecutive cycles (all 01, then all 10) -> writes 12'h555@0 and 12'hAAA@1, exactly 2 pulses, no dropped nibs.
3. start, 3 nibs 11,11,11, flush -> wr_data=12'hFC0 @0, done=1, state IDLE; a second flush produces no write.
4. MAX_WORDS=4: start, 24 nibs, then 1 more nib -> 4 writes (addr 0..3), done=1 after the 4th write, overflow=1, no 5th write.
5. start, 5 nibs, start again, 6 nibs 00 -> single write 12'h000 @0; the first partial word is never written.
6. PACKER_CHECKSUM_EN defined: write 12'h555 then 12'hAAA -> checksum=12'hFFF; start -> checksum=0; undefined build -> checksum stays 0.

Source files
------------

// File: rtl/nib_word_packer.sv
// nib_word_packer: packs 2-bit colour codes MSB-first into program words and
// writes each finished word to the program RAM at an auto-incrementing address.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-low reset
//   start      in   pulse: clear address, nib count and flags; arm the packer
//   nib_valid  in   pulse: nib carries a new colour code
//   nib        in   2-bit colour code (00 red, 01 green, 10 blue, 11 yellow)
//   flush      in   pulse: end of cartridge; zero-pad and write any partial word
//   wr_en      out  single-cycle RAM write strobe
//   wr_addr    out  RAM write address, valid while wr_en=1
//   wr_data    out  RAM write data, valid while wr_en=1
//   word_count out  words written since start
//   busy       out  1 while collecting
//   done       out  sticky: flush completed or RAM full; cleared by start
//   overflow   out  sticky: nib arrived while full; cleared by start
//   checksum   out  running XOR of written words when PACKER_CHECKSUM_EN is
//                   defined, otherwise tied to 0
//
// Optional feature macro: PACKER_CHECKSUM_EN
module nib_word_packer #(
    parameter int NIBS_PER_WORD = 6,
    parameter int WORD_W        = 12,
    parameter int ADDR_W        = 8,
    parameter int MAX_WORDS     = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              nib_valid,
    input  logic [1:0]        nib,
    input  logic              flush,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [WORD_W-1:0] checksum
);
    localparam int CW = $clog2(NIBS_PER_WORD + 1);
    localparam int SW = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

    state_t          state;
    logic [WORD_W-1:0] sr;
    logic [CW-1:0]     cnt;

    logic [WORD_W-1:0] sh, sr_acc, pad, wdata;
    logic [CW-1:0]     cnt_acc;
    logic [SW-1:0]     shamt;
    logic              last, wr_go, at_end;

    // The nib of this cycle is folded in before flush is considered, so a
    // nib+flush pair that completes a word yields exactly one write.
    always_comb begin
        sh      = {sr[WORD_W-3:0], nib};
        last    = nib_valid && cnt == CW'(NIBS_PER_WORD - 1);
        sr_acc  = nib_valid ? sh : sr;
        cnt_acc = nib_valid ? cnt + CW'(1) : cnt;
        shamt   = SW'(WORD_W - 2 * int'(cnt_acc));
        pad     = sr_acc << shamt;
        wdata   = last ? sh : pad;
        wr_go   = state == COLLECT && (last || (flush && cnt_acc != '0));
        at_end  = word_count == (ADDR_W+1)'(MAX_WORDS - 1);
    end

    assign busy = state == COLLECT;

`ifdef PACKER_CHECKSUM_EN
    logic [WORD_W-1:0] csum;
    assign checksum = csum;
`else
    assign checksum = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sr         <= '0;
            cnt        <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            word_count <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
`ifdef PACKER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (start) begin
                state      <= COLLECT;
                sr         <= '0;
                cnt        <= '0;
                word_count <= '0;
                done       <= 1'b0;
                overflow   <= 1'b0;
`ifdef PACKER_CHECKSUM_EN
                csum       <= '0;
`endif
            end else begin
                case (state)
                    COLLECT: begin
                        if (wr_go) begin
                            wr_en      <= 1'b1;
                            wr_data    <= wdata;
                            wr_addr    <= word_count[ADDR_W-1:0];
                            word_count <= word_count + 1'b1;
                            sr         <= '0;
                            cnt        <= '0;
`ifdef PACKER_CHECKSUM_EN
                            csum       <= csum ^ wdata;
`endif
                        end else begin
                            sr  <= sr_acc;
                            cnt <= cnt_acc;
                        end
                        // Writing the last address ends loading for good: no wrap.
                        if (wr_go && at_end) begin
                            state <= FULL;
                            done  <= 1'b1;
                        end else if (flush) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                    FULL: begin
                        if (nib_valid) overflow <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_nib_word_packer.sv
// tb_nib_word_packer: directed and random stimulus checked against a queue-based model.
module tb_nib_word_packer;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, nib_valid = 1'b0, flush = 1'b0;
    logic [1:0]  nib = 2'b00;
    logic        wr_en, busy, done, overflow;
    logic [7:0]  wr_addr;
    logic [11:0] wr_data, checksum;
    logic [8:0]  word_count;

    nib_word_packer #(.MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .start(start), .nib_valid(nib_valid), .nib(nib),
        .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .word_count(word_count), .busy(busy), .done(done), .overflow(overflow),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;

    int m_mode = 0;
    int m_pend[$];
    int m_words = 0, m_done = 0, m_ovf = 0, m_cks = 0, m_wr = 0, m_addr = 0, m_data = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_mode = 0; m_pend.delete(); m_words = 0; m_done = 0; m_ovf = 0; m_cks = 0; m_wr = 0;
    endtask

    function automatic int make_word();
        int w = 0;
        for (int i = 0; i < 6; i++) w = (w << 2) | (i < m_pend.size() ? m_pend[i] : 0);
        return w;
    endfunction

    task automatic model_step(input bit st, input bit nv, input int n, input bit fl);
        m_wr = 0;
        if (st) begin
            m_mode = 1; m_pend.delete(); m_words = 0; m_done = 0; m_ovf = 0; m_cks = 0;
        end else if (m_mode == 1) begin
            if (nv) m_pend.push_back(n);
            if (m_pend.size() == 6 || (fl && m_pend.size() > 0)) begin
                m_wr = 1; m_addr = m_words; m_data = make_word();
                m_words++; m_cks ^= m_data; m_pend.delete();
                if (m_words == MAXW) begin m_mode = 2; m_done = 1; end
                else if (fl) begin m_mode = 0; m_done = 1; end
            end else if (fl) begin
                m_mode = 0; m_done = 1;
            end
        end else if (m_mode == 2) begin
            if (nv) m_ovf = 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'(m_wr));
        if (m_wr != 0) begin
            chk({tag, "_addr"}, 32'(wr_addr), 32'(m_addr));
            chk({tag, "_data"}, 32'(wr_data), 32'(m_data));
        end
        chk({tag, "_count"}, 32'(word_count), 32'(m_words));
        chk({tag, "_busy"}, 32'(busy), 32'(m_mode == 1));
        chk({tag, "_done"}, 32'(done), 32'(m_done));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
`ifdef PACKER_CHECKSUM_EN
        chk({tag, "_cks"}, 32'(checksum), 32'(m_cks));
`else
        chk({tag, "_cks"}, 32'(checksum), 32'h0);
`endif
    endtask

    task automatic step(input string tag, input bit st, input bit nv, input int n, input bit fl);
        start = st; nib_valid = nv; nib = 2'(n); flush = fl;
        model_step(st, nv, n, fl);
        @(posedge clk); #1;
        start = 0; nib_valid = 0; flush = 0;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int k);
        for (int i = 0; i < k; i++) step(tag, 0, 0, 0, 0);
    endtask

    int t1[6] = '{3, 2, 1, 0, 3, 2};

    initial begin
        model_reset();
        #12;
        check_all("reset");
        reset = 1;
        @(posedge clk); #1;

        step("t1_start", 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            idle("t1_gap", 40);
            step("t1_nib", 0, 1, t1[i], 0);
        end
        chk("t1_word", 32'(wr_data), 32'hE4E);
        idle("t1_after", 3);

        step("t2_start", 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step("t2_nib", 0, 1, i < 6 ? 1 : 2, 0);
        chk("t2_last", 32'(wr_data), 32'hAAA);
        idle("t2_after", 2);

        step("t3_start", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("t3_nib", 0, 1, 3, 0);
        step("t3_flush", 0, 0, 0, 1);
        chk("t3_pad", 32'(wr_data), 32'hFC0);
        step("t3_flush2", 0, 0, 0, 1);
        idle("t3_after", 2);

        step("t4_start", 1, 0, 0, 0);
        for (int i = 0; i < 24; i++) step("t4_nib", 0, 1, i % 4, 0);
        step("t4_extra", 0, 1, 1, 0);
        step("t4_flush", 0, 0, 0, 1);
        idle("t4_after", 2);

        step("t5_start", 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("t5_part", 0, 1, 3, 0);
        step("t5_restart", 1, 1, 2, 0);
        for (int i = 0; i < 6; i++) step("t5_nib", 0, 1, 0, 0);
        idle("t5_after", 2);

        step("t6_start", 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("t6_nib", 0, 1, 2, 0);
        step("t6_nibflush", 0, 1, 2, 1);
        idle("t6_after", 2);

        step("t7_start", 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("t7_nib", 0, 1, 1, 0);
        reset = 0; #1;
        model_reset();
        check_all("t7_async");
        #2 reset = 1;
        idle("t7_after", 3);

        for (int i = 0; i < 600; i++)
            step("rnd", $urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 3)), $urandom_range(0, 24) == 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
